// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: turns a sync_fifo request/1-cycle-latency read port into a
// valid/ready stream. Reads are issued speculatively against skid-buffer credit so
// the stream can sustain one beat per cycle; flush discards buffered/in-flight data.
module fifo_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_valid,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  err_overflow,
    output logic                  err_unexpected
);

    localparam int IDX_WIDTH = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(BUF_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(BUF_DEPTH);
    localparam logic [CNT_WIDTH:0]   DEPTH_EXT = (CNT_WIDTH + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [CNT_WIDTH-1:0]  count;
    logic                  inflight;
    logic                  drop;

    logic                  pop;
    logic                  do_pop;
    logic                  full;
    logic                  ret_ok;
    logic                  push;
    logic                  overflow_evt;
    logic                  unexp_evt;
    logic [CNT_WIDTH:0]    committed;

    // Explicit wrap so non-power-of-2 depths index correctly.
    function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
    endfunction

    // Stream outputs, credit check and buffer update qualifiers.
    always_comb begin
        m_valid   = (count != '0);
        m_data    = mem[rd_idx];
        occupancy = count;
        pop       = m_valid && m_ready;
        full      = (count == FULL_CNT);
        // pop implies count >= 1, so this never underflows.
        committed = {1'b0, count} + {{CNT_WIDTH{1'b0}}, inflight}
                  - {{CNT_WIDTH{1'b0}}, pop};
        fifo_rd_en   = rst_n && !fifo_empty && !flush && (committed < DEPTH_EXT);
        ret_ok       = fifo_rd_valid && inflight && !drop;
        do_pop       = pop && !flush;
        push         = ret_ok && !flush && (!full || pop);
        overflow_evt = ret_ok && !flush && full && !pop;
        unexp_evt    = fifo_rd_valid && !inflight && !drop;
    end

    // Skid buffer storage; flush only resets the indices, not the contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_idx] <= fifo_dout;
        end
    end

    // Indices and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (do_pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            if (push && !do_pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    // In-flight tracking, flush drop marker and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight       <= 1'b0;
            drop           <= 1'b0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            // A return landing in the flush cycle is discarded by the flush itself,
            // so only an outstanding read that has not yet returned needs a drop.
            drop <= (drop || (flush && inflight)) && !fifo_rd_valid;
            if (overflow_evt) begin
                err_overflow <= 1'b1;
            end
            if (unexp_evt) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: queue-based behavioural model of the adapter plus a
// model of sync_fifo's read port, checked every cycle, with directed literal checks.
module tb_fifo_stream_adapter;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          fifo_rd_valid;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          flush;
    logic [CW-1:0] occupancy;
    logic          err_overflow;
    logic          err_unexpected;

    fifo_stream_adapter #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_valid  (fifo_rd_valid),
        .fifo_dout      (fifo_dout),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .flush          (flush),
        .occupancy      (occupancy),
        .err_overflow   (err_overflow),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Upstream FIFO model
    logic [DW-1:0] fq[$];
    bit            ret_pending = 1'b0;
    logic [DW-1:0] ret_data    = '0;
    bit            inject      = 1'b0;

    // Adapter model: buffer contents as a queue
    logic [DW-1:0] mq[$];
    bit            m_infl = 1'b0;
    bit            m_drop = 1'b0;
    bit            m_eo   = 1'b0;
    bit            m_eu   = 1'b0;

    // Observation logs for directed checks
    int            cyc = 0;
    int            rden_cnt;
    int            first_rden;
    int            last_rden;
    int            first_valid;
    logic [DW-1:0] beats[$];
    int            beat_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        rden_cnt    = 0;
        first_rden  = -1;
        last_rden   = -1;
        first_valid = -1;
        beats.delete();
        beat_cyc.delete();
    endtask

    // One clock cycle: drive FIFO-side inputs, compare at negedge, advance models.
    task automatic run_cycle();
        int            sz;
        int            pop_e;
        int            rden_e;
        logic          rv;
        logic [DW-1:0] dv;
        rv            = ret_pending || inject;
        dv            = ret_pending ? ret_data : 8'hEE;
        fifo_empty    = (fq.size() == 0);
        fifo_rd_valid = rv;
        fifo_dout     = dv;
        @(negedge clk);
        sz     = mq.size();
        pop_e  = (sz > 0 && m_ready) ? 1 : 0;
        rden_e = (rst_n && fq.size() > 0 && !flush && (sz + int'(m_infl) - pop_e) < DEPTH)
                 ? 1 : 0;
        chk("rd_en", 32'(fifo_rd_en), 32'(rden_e));
        chk("m_valid", 32'(m_valid), 32'(sz > 0));
        if (sz > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        chk("occupancy", 32'(occupancy), 32'(sz));
        chk("err_overflow", 32'(err_overflow), 32'(m_eo));
        chk("err_unexpected", 32'(err_unexpected), 32'(m_eu));

        if (fifo_rd_en) begin
            rden_cnt++;
            if (first_rden < 0) first_rden = cyc;
            last_rden = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (rst_n && m_valid && m_ready && !flush) begin
            beats.push_back(m_data);
            beat_cyc.push_back(cyc);
        end

        if (!rst_n) begin
            mq.delete();
            m_infl = 1'b0;
            m_drop = 1'b0;
            m_eo   = 1'b0;
            m_eu   = 1'b0;
        end else begin
            if (rv && !m_infl && !m_drop) m_eu = 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop_e != 0) void'(mq.pop_front());
                if (rv && m_infl && !m_drop) begin
                    if (mq.size() < DEPTH) mq.push_back(dv);
                    else m_eo = 1'b1;
                end
            end
            m_drop = (m_drop || (flush && m_infl)) && !rv;
            m_infl = (rden_e != 0);
        end

        if (rst_n && fifo_rd_en && fq.size() > 0) begin
            ret_pending = 1'b1;
            ret_data    = fq.pop_front();
        end else begin
            ret_pending = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        m_ready       = 1'b0;
        flush         = 1'b0;
        fifo_empty    = 1'b0;
        fifo_rd_valid = 1'b0;
        fifo_dout     = '0;
        clear_logs();
        for (int i = 0; i < 8; i++) fq.push_back(8'(8'h10 + i));
        @(posedge clk);
        #1;

        // Reset held with a non-empty FIFO
        repeat (3) run_cycle();
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_errs", {30'd0, err_overflow, err_unexpected}, 32'd0);

        // Streaming 0x10..0x17 with m_ready high
        rst_n   = 1'b1;
        m_ready = 1'b1;
        clear_logs();
        repeat (14) run_cycle();
        chk("stream_latency", 32'(first_valid - first_rden), 32'd2);
        chk("stream_rden_cnt", 32'(rden_cnt), 32'd8);
        chk("stream_rden_run", 32'(last_rden - first_rden), 32'd7);
        chk("stream_beats", 32'(beats.size()), 32'd8);
        if (beats.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("stream_data", 32'(beats[i]), 32'(8'h10 + i));
            chk("stream_no_bubble", 32'(beat_cyc[7] - beat_cyc[0]), 32'd7);
        end

        // Backpressure with 5 words available
        m_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 5; i++) fq.push_back(8'(8'h20 + i));
        repeat (6) run_cycle();
        chk("bp_rden_cnt", 32'(rden_cnt), 32'(DEPTH));
        chk("bp_occupancy", 32'(occupancy), 32'(DEPTH));
        chk("bp_head", 32'(m_data), 32'h20);
        m_ready = 1'b1;
        clear_logs();
        repeat (10) run_cycle();
        chk("bp_beats", 32'(beats.size()), 32'd5);
        if (beats.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("bp_data", 32'(beats[i]), 32'(8'h20 + i));
        end

        // Flush in the cycle after a read was issued
        clear_logs();
        fq.push_back(8'h30);
        fq.push_back(8'h31);
        run_cycle();
        chk("fl_rd_issued", 32'(rden_cnt), 32'd1);
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        chk("fl_occupancy", 32'(occupancy), 32'd0);
        chk("fl_m_valid", 32'(m_valid), 32'd0);
        repeat (6) run_cycle();
        chk("fl_beats", 32'(beats.size()), 32'd1);
        if (beats.size() == 1) chk("fl_next_word", 32'(beats[0]), 32'h31);

        // Randomized traffic: stalls, flushes, occasional reset
        for (int n = 0; n < 3000; n++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 24) == 0);
            rst_n   = ($urandom_range(0, 399) != 0);
            if (!rst_n) fq.delete();
            else if ($urandom_range(0, 2) != 0 && fq.size() < 16) fq.push_back(8'($urandom));
            run_cycle();
        end
        rst_n   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (40) run_cycle();
        chk("drained_occ", 32'(occupancy), 32'd0);
        chk("no_overflow", 32'(err_overflow), 32'd0);

        // Return with no read in flight
        inject = 1'b1;
        run_cycle();
        inject = 1'b0;
        chk("unexp_set", 32'(err_unexpected), 32'd1);
        chk("unexp_occ", 32'(occupancy), 32'd0);
        repeat (3) run_cycle();
        chk("unexp_sticky", 32'(err_unexpected), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
